instr_line_responder: RTL



---
 rtl/instr_line_responder_pkg.sv | 23 ++
 rtl/intf_csb.sv | 10 +
 rtl/instr_line_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/instr_line_responder_pkg.sv
// Shared definitions for the instruction-cache line-fill responder.
package instr_line_responder_pkg;

    localparam int LINE_WORDS       = 8;
    localparam int WORD_BITS        = 32;
    localparam int LINE_BITS        = LINE_WORDS * WORD_BITS;
    localparam int LINE_OFFSET_BITS = 5;
    localparam int TAG_BITS         = 32 - LINE_OFFSET_BITS;
    localparam int K_BITS           = 3;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE,
        COOL
    } line_resp_state_e;

    // Align a byte address down to the start of its 32-byte line.
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/intf_csb.sv
// Clock/reset bundle shared by blocks on the cache subsystem bus.
interface IntfCSB;
    logic clock;
    logic reset;

    modport notag (
        input clock,
        input reset
    );
endinterface

// File: rtl/instr_line_responder.sv
// Memory-side responder for the instruction-cache line-fill port: fetches
// the eight words of a line one read at a time, packs them into a 256-bit
// line, and answers a repeat of the last line from a one-entry buffer.
module instr_line_responder
    import instr_line_responder_pkg::*;
#(
    parameter int USE_LINE_BUFFER = 1
) (
    IntfCSB.notag              cs,
    input  logic [31:0]        i_address,
    input  logic               i_read,
    output logic [LINE_BITS-1:0] o_data,
    output logic               o_ready,
    output logic [31:0]        o_word_address,
    output logic               o_word_read,
    input  logic [31:0]        i_word_data,
    input  logic               i_word_valid,
    output logic               o_busy
);

    line_resp_state_e        state_q, state_d;
    logic [K_BITS-1:0]       k_q, k_d;
    logic [31:0]             base_q, base_d;
    logic [LINE_BITS-1:0]    line_q, line_d;
    logic                    pending_q, pending_d;
    logic                    word_read_q, word_read_d;
    logic                    buf_valid_q, buf_valid_d;
    logic [TAG_BITS-1:0]     buf_tag_q, buf_tag_d;
    logic [LINE_BITS-1:0]    buf_line_q, buf_line_d;

    logic                    buf_hit;
    logic                    word_accept;
    logic                    unused_addr_bits;

    // The offset bits of the request never select anything: fills are whole lines.
    assign unused_addr_bits = ^i_address[LINE_OFFSET_BITS-1:0];

    // Repeat-line detection and acceptance of a returning word.
    always_comb begin
        buf_hit     = (USE_LINE_BUFFER != 0) && buf_valid_q &&
                      (buf_tag_q == i_address[31:LINE_OFFSET_BITS]);
        // Data is only taken for a read that is outstanding; a valid in the
        // strobe cycle itself or with nothing in flight is stale.
        word_accept = (state_q == FETCH) && pending_q && !word_read_q && i_word_valid;
    end

    // Next-state, fill datapath and buffer update.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d     = state_q;
        k_d         = k_q;
        base_d      = base_q;
        line_d      = line_q;
        pending_d   = pending_q;
        word_read_d = 1'b0;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_line_d  = buf_line_q;

        unique case (state_q)
            IDLE: begin
                if (i_read) begin
                    base_d = line_base(i_address);
                    k_d    = '0;
                    if (buf_hit) begin
                        line_d  = buf_line_q;
                        state_d = DONE;
                    end else begin
                        line_d      = '0;
                        word_read_d = 1'b1;
                        pending_d   = 1'b1;
                        state_d     = FETCH;
                    end
                end
            end

            FETCH: begin
                if (word_accept) begin
                    // Word k lands at [255-32k -: 32], so word 0 is the MSW.
                    for (int w = 0; w < LINE_WORDS; w++) begin
                        if (k_q == K_BITS'(w)) begin
                            line_d[LINE_BITS-1-WORD_BITS*w -: WORD_BITS] = i_word_data;
                        end
                    end
                    pending_d = 1'b0;
                    if (k_q == K_BITS'(LINE_WORDS - 1)) begin
                        state_d = DONE;
                    end else begin
                        k_d         = k_q + 1'b1;
                        word_read_d = 1'b1;
                        pending_d   = 1'b1;
                    end
                end
            end

            DONE: begin
                buf_valid_d = (USE_LINE_BUFFER != 0);
                buf_tag_d   = base_q[31:LINE_OFFSET_BITS];
                buf_line_d  = line_q;
                state_d     = COOL;
            end

            // The cache's registered request is still high and stale here.
            COOL: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and fill state; reset aborts any fill and invalidates the buffer.
    always_ff @(posedge cs.clock) begin
        // NOTE: state flops use non-blocking assignment so every flop samples
        // the pre-edge values regardless of statement order.
        if (cs.reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            base_q      <= '0;
            line_q      <= '0;
            pending_q   <= 1'b0;
            word_read_q <= 1'b0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            base_q      <= base_d;
            line_q      <= line_d;
            pending_q   <= pending_d;
            word_read_q <= word_read_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    // Buffered line contents, qualified entirely by buf_valid_q.
    always_ff @(posedge cs.clock) begin
        // NOTE: the tag and line storage carry no reset; the valid bit alone
        // decides whether they are ever looked at.
        buf_tag_q  <= buf_tag_d;
        buf_line_q <= buf_line_d;
    end

    // Output decode: everything is zero outside the states that own it.
    always_comb begin
        o_ready        = (state_q == DONE);
        o_data         = (state_q == DONE) ? line_q : '0;
        o_word_read    = word_read_q;
        o_word_address = (state_q == FETCH)
                       ? (base_q | {{(32-LINE_OFFSET_BITS){1'b0}}, k_q, 2'b00})
                       : '0;
        o_busy         = (state_q != IDLE);
    end

endmodule
